// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding,
// default geometry and the digit-counter width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W     = 12;
    localparam int DEF_DIGIT = 2;

    // A counter for a single digit still needs one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_sub.sv
// Combinational DIGIT-bit subtractor with borrow in/out, shared by the
// digit-serial arithmetic blocks.
module digit_sub #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] diff;

    // The extra top bit of the widened difference is set exactly when a-b-bin < 0.
    assign diff = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    assign d    = diff[DIGIT-1:0];
    assign bout = diff[DIGIT];

endmodule

// File: rtl/operand_recover_serial.sv
// Digit-serial inverse of a W-bit adder: recovers B = S - A from the (W+1)-bit
// sum and one addend, flagging differences outside the range [0, 2^W).
module operand_recover_serial
    import arith_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   in_sum,
    input  logic [W-1:0] in_addend,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_operand,
    output logic         out_err
);

    localparam int NDIG = W / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (DIGIT < 1 || (W % DIGIT) != 0) begin : g_bad_geometry
        $error("operand_recover_serial: W must be a positive multiple of DIGIT");
    end

    state_t              state;
    logic [W-1:0]        s_sh;
    logic [W-1:0]        a_sh;
    logic                s_top;
    logic                borrow;
    logic [CW-1:0]       cnt;
    logic [W-1:0]        res;
    logic [DIGIT-1:0]    d;
    logic                bout;
    logic [W+DIGIT-1:0]  res_cat;
    logic [W-1:0]        next_res;
    logic                accept;

    digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
        .a    (s_sh[DIGIT-1:0]),
        .b    (a_sh[DIGIT-1:0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    // New digits enter at the MSB so the LSB digit ends up at bit 0 after NDIG steps.
    assign res_cat  = {d, res};
    assign next_res = res_cat[W+DIGIT-1:DIGIT];

    assign out_valid = (state == DONE);
    assign in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s_sh        <= '0;
            a_sh        <= '0;
            s_top       <= 1'b0;
            borrow      <= 1'b0;
            cnt         <= '0;
            res         <= '0;
            out_operand <= '0;
            out_err     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        s_sh   <= in_sum[W-1:0];
                        a_sh   <= in_addend;
                        s_top  <= in_sum[W];
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    res    <= next_res;
                    borrow <= bout;
                    s_sh   <= s_sh >> DIGIT;
                    a_sh   <= a_sh >> DIGIT;
                    cnt    <= cnt + 1'b1;
                    // S[W] cancels a final borrow; a mismatch means S-A left [0, 2^W).
                    if (cnt == LAST) begin
                        out_operand <= next_res;
                        out_err     <= s_top ^ bout;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_recover_serial.sv
// Directed and randomized checks of operand_recover_serial, plus a small
// DIGIT sweep using extra instances driven in lockstep.
module tb_operand_recover_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_sum;
    logic [11:0] in_addend;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_operand;
    logic        out_err;

    int n_vec = 0;
    int n_err = 0;

    operand_recover_serial #(.W(12), .DIGIT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_addend   (in_addend),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_operand (out_operand),
        .out_err     (out_err)
    );

    // Sweep instances: DIGIT = 1, 3, 4, 6, all fed the same pair at once.
    logic        sw_valid;
    logic [12:0] sw_sum;
    logic [11:0] sw_addend;
    logic        sw_in_ready  [4];
    logic        sw_out_valid [4];
    logic [11:0] sw_op        [4];
    logic        sw_err       [4];

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 6;
        operand_recover_serial #(.W(12), .DIGIT(DG)) u_sw (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (sw_valid),
            .in_ready    (sw_in_ready[g]),
            .in_sum      (sw_sum),
            .in_addend   (sw_addend),
            .out_valid   (sw_out_valid[g]),
            .out_ready   (1'b1),
            .out_operand (sw_op[g]),
            .out_err     (sw_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [12:0] s, input logic [11:0] a);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_sum    = s;
        in_addend = a;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input logic [11:0] exp_op, input logic exp_err);
        n_vec++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("[TB] FAIL %s_latency got=%0d required=%0d", name, lat, exp_lat);
        end
        n_vec++;
        if (out_operand !== exp_op) begin
            n_err++;
            $display("[TB] FAIL %s_operand got=%h required=%h", name, out_operand, exp_op);
        end
        n_vec++;
        if (out_err !== exp_err) begin
            n_err++;
            $display("[TB] FAIL %s_err got=%0b required=%0b", name, out_err, exp_err);
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_addend = '0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_sum    = '0;
        sw_addend = '0;
        tick;
        tick;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_in_ready_during got=%0b required=0", in_ready);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_in_ready got=%0b required=1", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b0 || out_operand !== 12'h000 || out_err !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs got=%0b/%h/%0b required=0/000/0",
                     out_valid, out_operand, out_err);
        end
    endtask

    task automatic test_latency;
        int lat;
        out_ready = 1'b1;
        send_pair(13'h1FFE, 12'hFFF);
        wait_valid(lat);
        check_result("max_sum", lat, 6, 12'hFFF, 1'b0);
        tick;
    endtask

    task automatic test_negative;
        int lat;
        send_pair(13'h0005, 12'h007);
        wait_valid(lat);
        check_result("negative", lat, 6, 12'hFFE, 1'b1);
        tick;
    endtask

    task automatic test_range;
        int lat;
        send_pair(13'h1000, 12'h000);
        wait_valid(lat);
        check_result("overflow", lat, 6, 12'h000, 1'b1);
        tick;
        send_pair(13'h0FFF, 12'h000);
        wait_valid(lat);
        check_result("top_in_range", lat, 6, 12'hFFF, 1'b0);
        tick;
    endtask

    task automatic test_back_to_back;
        int lat;
        out_ready = 1'b0;
        send_pair(13'h0A00, 12'h100);
        wait_valid(lat);
        check_result("stall_first", lat, 6, 12'h900, 1'b0);
        in_valid  = 1'b1;
        in_sum    = 13'h0010;
        in_addend = 12'h003;
        #1;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_operand !== 12'h900 || out_err !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL stall_hold cyc=%0d got=%0b/%h/%0b required=1/900/0",
                         i, out_valid, out_operand, out_err);
            end
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL stall_in_ready cyc=%0d got=%0b required=0", i, in_ready);
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL release_in_ready got=%0b required=1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL release_consumed out_valid=%0b required=0", out_valid);
        end
        wait_valid(lat);
        check_result("back_to_back", lat, 6, 12'h00D, 1'b0);
        tick;
    endtask

    task automatic test_reset_midop;
        bit stale;
        out_ready = 1'b1;
        send_pair(13'h1FFE, 12'hFFF);
        tick;
        tick;
        rst = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midop_in_ready_rst got=%0b required=0", in_ready);
        end
        tick;
        n_vec++;
        if (out_valid !== 1'b0 || out_operand !== 12'h000 || out_err !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midop_outputs got=%0b/%h/%0b required=0/000/0",
                     out_valid, out_operand, out_err);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL midop_in_ready got=%0b required=1", in_ready);
        end
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (out_valid) stale = 1'b1;
        end
        n_vec++;
        if (stale !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midop_stale_result seen=%0b required=0", stale);
        end
    endtask

    task automatic test_random;
        logic [11:0] q_op [$];
        logic        q_err [$];
        logic [11:0] e_op;
        logic        e_err;
        int          diff;
        int          accepted;
        int          cycles;
        accepted = 0;
        cycles   = 0;
        while ((accepted < 2000 || q_op.size() != 0) && cycles < 60000) begin
            in_valid  = (accepted < 2000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            in_sum    = 13'($urandom);
            in_addend = 12'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (q_op.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL random_unexpected got=%h required=none", out_operand);
                end else begin
                    e_op  = q_op.pop_front();
                    e_err = q_err.pop_front();
                    if (out_operand !== e_op || out_err !== e_err) begin
                        n_err++;
                        $display("[TB] FAIL random_result got=%h/%0b required=%h/%0b",
                                 out_operand, out_err, e_op, e_err);
                    end
                end
            end
            if (in_valid && in_ready) begin
                diff = int'(in_sum) - int'(in_addend);
                q_op.push_back(diff[11:0]);
                q_err.push_back(diff < 0 || diff >= 4096);
                accepted++;
            end
            tick;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (cycles >= 60000) begin
            n_err++;
            $display("[TB] FAIL random_timeout accepted=%0d pending=%0d required=2000/0",
                     accepted, q_op.size());
        end
        tick;
    endtask

    task automatic sweep_one(input logic [12:0] s, input logic [11:0] a,
                             input logic [11:0] exp_op, input logic exp_err);
        int   lat  [4];
        bit   seen [4];
        logic [11:0] got_op [4];
        logic        got_err [4];
        int   exp_lat [4];
        exp_lat = '{12, 4, 3, 2};
        for (int g = 0; g < 4; g++) begin
            seen[g] = 1'b0;
            lat[g]  = 0;
        end
        sw_valid  = 1'b1;
        sw_sum    = s;
        sw_addend = a;
        tick;
        sw_valid = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick;
            for (int g = 0; g < 4; g++) begin
                if (!seen[g] && sw_out_valid[g]) begin
                    seen[g]    = 1'b1;
                    lat[g]     = t;
                    got_op[g]  = sw_op[g];
                    got_err[g] = sw_err[g];
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            n_vec++;
            if (!seen[g] || lat[g] != exp_lat[g] || got_op[g] !== exp_op || got_err[g] !== exp_err) begin
                n_err++;
                $display("[TB] FAIL sweep_inst%0d s=%h a=%h got seen=%0b lat=%0d %h/%0b required lat=%0d %h/%0b",
                         g, s, a, seen[g], lat[g], got_op[g], got_err[g], exp_lat[g], exp_op, exp_err);
            end
        end
    endtask

    task automatic test_sweep;
        sweep_one(13'h1FFE, 12'hFFF, 12'hFFF, 1'b0);
        sweep_one(13'h0005, 12'h007, 12'hFFE, 1'b1);
        sweep_one(13'h1000, 12'h000, 12'h000, 1'b1);
        sweep_one(13'h0ABC, 12'h123, 12'h999, 1'b0);
    endtask

    initial begin
        test_reset;
        test_latency;
        test_negative;
        test_range;
        test_back_to_back;
        test_reset_midop;
        test_random;
        test_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
